// File: rtl/feed_scheduler.sv
// Feed scheduler: counts down the feeding interval on 1 Hz ticks, runs the dispense motor
// for the portion time, enforces a cooldown after each feed and latches a fault on an
// empty hopper. All outputs decode from registers only.
module feed_scheduler #(
    parameter int unsigned INTERVAL_W   = 17,
    parameter int unsigned PORTION_W    = 6,
    parameter int unsigned COOLDOWN_SEC = 5,
    parameter int unsigned COUNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic [PORTION_W-1:0]  portion,
    input  logic                  manual_req,
    input  logic                  food_empty,
    input  logic                  fault_clr,
    output logic                  motor_on,
    output logic                  timer_en,
    output logic                  fault,
    output logic [INTERVAL_W-1:0] remaining,
    output logic [COUNT_W-1:0]    feed_count,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWait     = 3'd1,
        StDispense = 3'd2,
        StCooldown = 3'd3,
        StFault    = 3'd4
    } state_e;

    localparam logic [INTERVAL_W-1:0] CooldownLoad = INTERVAL_W'(COOLDOWN_SEC);
    localparam logic [INTERVAL_W-1:0] RemOne       = INTERVAL_W'(1);
    localparam logic [COUNT_W-1:0]    CountOne     = COUNT_W'(1);

    state_e                  state_q, state_d;
    logic [INTERVAL_W-1:0]   rem_q, rem_d;
    logic [COUNT_W-1:0]      count_q, count_d;
    logic                    manual_req_q;

    logic                    man_edge;
    logic                    last_tick;
    state_e                  entry_state;
    logic [INTERVAL_W-1:0]   entry_rem;
    state_e                  resume_state;
    logic [INTERVAL_W-1:0]   resume_rem;

    assign man_edge  = manual_req & ~manual_req_q;
    // The tick that finishes the current second count.
    assign last_tick = tick && (rem_q == RemOne);

    // Where a feed request lands: fault on empty hopper, skip the motor for a zero portion.
    always_comb begin
        entry_state = StDispense;
        entry_rem   = INTERVAL_W'(portion);
        if (food_empty) begin
            entry_state = StFault;
            entry_rem   = '0;
        end else if (portion == '0) begin
            entry_state = StCooldown;
            entry_rem   = CooldownLoad;
        end
    end

    // Where the schedule resumes once a cooldown has elapsed.
    always_comb begin
        resume_state = StIdle;
        resume_rem   = '0;
        if (enable && (interval != '0)) begin
            resume_state = StWait;
            resume_rem   = interval;
        end
    end

    // Next-state, second-counter and feed-counter logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (man_edge) begin
                    state_d = entry_state;
                    rem_d   = entry_rem;
                end else if (enable && (interval != '0)) begin
                    state_d = StWait;
                    rem_d   = interval;
                end
            end
            StWait: begin
                if (!enable) begin
                    state_d = StIdle;
                    rem_d   = '0;
                end else if (man_edge || last_tick) begin
                    // A manual edge on the expiry tick still yields a single feed.
                    state_d = entry_state;
                    rem_d   = entry_rem;
                end else if (tick) begin
                    rem_d = rem_q - RemOne;
                end
            end
            StDispense: begin
                if (food_empty) begin
                    state_d = StFault;
                    rem_d   = '0;
                end else if (last_tick) begin
                    state_d = StCooldown;
                    rem_d   = CooldownLoad;
                    if (count_q != '1) begin
                        count_d = count_q + CountOne;
                    end
                end else if (tick) begin
                    rem_d = rem_q - RemOne;
                end
            end
            StCooldown: begin
                // A zero load means the cooldown ends on the cycle after entry.
                if ((rem_q == '0) || last_tick) begin
                    state_d = resume_state;
                    rem_d   = resume_rem;
                end else if (tick) begin
                    rem_d = rem_q - RemOne;
                end
            end
            StFault: begin
                rem_d = '0;
                if (fault_clr && !food_empty) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                rem_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            rem_q        <= '0;
            count_q      <= '0;
            manual_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            count_q      <= count_d;
            manual_req_q <= manual_req;
        end
    end

    // Registered-state output decode.
    always_comb begin
        motor_on   = (state_q == StDispense);
        fault      = (state_q == StFault);
        timer_en   = (state_q == StWait) || (state_q == StDispense) || (state_q == StCooldown);
        remaining  = rem_q;
        feed_count = count_q;
        state      = state_q;
    end

endmodule

// File: tb/tb_feed_scheduler.sv
// Self-checking bench for feed_scheduler: directed scenarios plus a randomized run compared
// cycle by cycle against a behavioural model of the feeding rules.
module tb_feed_scheduler;

    localparam int IW   = 17;
    localparam int PW   = 6;
    localparam int CD   = 2;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, tick, enable, manual_req, food_empty, fault_clr;
    logic [IW-1:0] interval;
    logic [PW-1:0] portion;
    logic          motor_on, timer_en, fault;
    logic [IW-1:0] remaining;
    logic [CW-1:0] feed_count;
    logic [2:0]    state;

    feed_scheduler #(
        .INTERVAL_W  (IW),
        .PORTION_W   (PW),
        .COOLDOWN_SEC(CD),
        .COUNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .enable    (enable),
        .interval  (interval),
        .portion   (portion),
        .manual_req(manual_req),
        .food_empty(food_empty),
        .fault_clr (fault_clr),
        .motor_on  (motor_on),
        .timer_en  (timer_en),
        .fault     (fault),
        .remaining (remaining),
        .feed_count(feed_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int period = 4;
    int phase = 0;
    bit rand_tick = 1'b0;

    // Behavioural model: mode 0..4 = idle, wait, dispense, cooldown, fault.
    int m_st, m_rem, m_cnt;
    bit m_man;

    function automatic void m_feed();
        if (food_empty) begin m_st = 4; m_rem = 0; end
        else if (portion == 0) begin m_st = 3; m_rem = CD; end
        else begin m_st = 2; m_rem = int'(portion); end
    endfunction

    function automatic void m_resume();
        if (enable && interval != 0) begin m_st = 1; m_rem = int'(interval); end
        else begin m_st = 0; m_rem = 0; end
    endfunction

    function automatic void model_step();
        bit edge_seen;
        edge_seen = manual_req && !m_man;
        m_man = reset ? 1'b0 : manual_req;
        if (reset) begin
            m_st = 0; m_rem = 0; m_cnt = 0;
            return;
        end
        case (m_st)
            0: if (edge_seen) m_feed();
               else if (enable && interval != 0) begin m_st = 1; m_rem = int'(interval); end
            1: if (!enable) begin m_st = 0; m_rem = 0; end
               else if (edge_seen || (tick && m_rem == 1)) m_feed();
               else if (tick) m_rem = m_rem - 1;
            2: if (food_empty) begin m_st = 4; m_rem = 0; end
               else if (tick && m_rem == 1) begin
                   m_st = 3; m_rem = CD;
                   m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
               end else if (tick) m_rem = m_rem - 1;
            3: if (m_rem == 0 || (tick && m_rem == 1)) m_resume();
               else if (tick) m_rem = m_rem - 1;
            default: begin
                m_rem = 0;
                if (fault_clr && !food_empty) m_st = 0;
            end
        endcase
    endfunction

    // One clock: pick this cycle's tick, advance the model, clock the DUT, sample after edge.
    task automatic step();
        if (rand_tick) tick = ($urandom_range(0, 3) == 0);
        else begin
            tick  = (phase == period - 1);
            phase = (phase + 1) % period;
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        phase = 0;
    endtask

    // Run while the DUT stays in state s; report ticks applied and cycles spent.
    task automatic dwell(input logic [2:0] s, input int budget, output int ticks, output int cycles);
        ticks = 0;
        cycles = 0;
        while (state == s && cycles < budget) begin
            step();
            if (tick) ticks++;
            cycles++;
        end
    endtask

    task automatic test_reset();
        enable = 0; interval = 0; portion = 0; manual_req = 0; food_empty = 0; fault_clr = 0;
        tick = 0;
        do_reset();
        tests++;
        if (state !== 3'd0 || remaining !== '0 || feed_count !== '0 || motor_on !== 1'b0 ||
            fault !== 1'b0 || timer_en !== 1'b0) begin
            fails++;
            $display("FAIL reset: state=%0d rem=%0d cnt=%0d motor=%b fault=%b ten=%b, required all 0",
                     state, remaining, feed_count, motor_on, fault, timer_en);
        end
    endtask

    task automatic test_auto_cycle();
        int tk, cy;
        enable = 1; interval = 3; portion = 2; period = 4;
        do_reset();
        step();
        tests++;
        if (state !== 3'd1 || remaining !== 17'd3 || timer_en !== 1'b1) begin
            fails++;
            $display("FAIL auto_wait_entry: state=%0d rem=%0d ten=%b, required 1/3/1",
                     state, remaining, timer_en);
        end
        dwell(3'd1, 60, tk, cy);
        tests++;
        if (cy >= 60 || tk != 3 || state !== 3'd2 || remaining !== 17'd2 || motor_on !== 1'b1) begin
            fails++;
            $display("FAIL auto_wait_expiry: ticks=%0d state=%0d rem=%0d motor=%b, required 3/2/2/1",
                     tk, state, remaining, motor_on);
        end
        dwell(3'd2, 60, tk, cy);
        tests++;
        if (cy >= 60 || tk != 2 || state !== 3'd3 || remaining !== 17'(CD) ||
            feed_count !== 2'd1 || motor_on !== 1'b0) begin
            fails++;
            $display("FAIL auto_dispense: ticks=%0d state=%0d rem=%0d cnt=%0d, required 2/3/%0d/1",
                     tk, state, remaining, feed_count, CD);
        end
        dwell(3'd3, 60, tk, cy);
        tests++;
        if (cy >= 60 || tk != 2 || state !== 3'd1 || remaining !== 17'd3) begin
            fails++;
            $display("FAIL auto_cooldown: ticks=%0d state=%0d rem=%0d, required 2/1/3",
                     tk, state, remaining);
        end
    endtask

    task automatic test_manual();
        int tk, cy;
        enable = 0; portion = 4; manual_req = 0; period = 4;
        do_reset();
        manual_req = 1;
        step();
        tests++;
        if (state !== 3'd2 || remaining !== 17'd4) begin
            fails++;
            $display("FAIL manual_entry: state=%0d rem=%0d, required 2/4", state, remaining);
        end
        dwell(3'd2, 100, tk, cy);
        tests++;
        if (cy >= 100 || tk != 4 || state !== 3'd3 || feed_count !== 2'd1) begin
            fails++;
            $display("FAIL manual_dispense: ticks=%0d state=%0d cnt=%0d, required 4/3/1",
                     tk, state, feed_count);
        end
        manual_req = 0;
        step();
        manual_req = 1;
        step();
        tests++;
        if (state !== 3'd3) begin
            fails++;
            $display("FAIL manual_cooldown_edge: state=%0d, required 3", state);
        end
        dwell(3'd3, 100, tk, cy);
        for (int i = 0; i < 20; i++) step();
        tests++;
        if (cy >= 100 || state !== 3'd0 || feed_count !== 2'd1 || motor_on !== 1'b0) begin
            fails++;
            $display("FAIL manual_single_feed: state=%0d cnt=%0d motor=%b, required 0/1/0",
                     state, feed_count, motor_on);
        end
        manual_req = 0;
    endtask

    task automatic test_fault();
        int tk, cy;
        enable = 0; portion = 5; manual_req = 0; food_empty = 0; fault_clr = 0; period = 4;
        do_reset();
        step();
        manual_req = 1;
        step();
        tk = 0; cy = 0;
        while (tk < 2 && cy < 50) begin
            step();
            if (tick) tk++;
            cy++;
        end
        food_empty = 1;
        step();
        tests++;
        if (cy >= 50 || state !== 3'd4 || motor_on !== 1'b0 || fault !== 1'b1 ||
            feed_count !== 2'd0 || timer_en !== 1'b0 || remaining !== '0) begin
            fails++;
            $display("FAIL fault_entry: state=%0d motor=%b fault=%b cnt=%0d ten=%b rem=%0d, req 4/0/1/0/0/0",
                     state, motor_on, fault, feed_count, timer_en, remaining);
        end
        fault_clr = 1;
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (state !== 3'd4 || fault !== 1'b1) begin
            fails++;
            $display("FAIL fault_hold: state=%0d fault=%b, required 4/1", state, fault);
        end
        food_empty = 0;
        step();
        tests++;
        if (state !== 3'd0 || fault !== 1'b0) begin
            fails++;
            $display("FAIL fault_clear: state=%0d fault=%b, required 0/0", state, fault);
        end
        fault_clr = 0;
        food_empty = 1;
        manual_req = 0;
        step();
        manual_req = 1;
        step();
        tests++;
        if (state !== 3'd4 || motor_on !== 1'b0) begin
            fails++;
            $display("FAIL fault_at_entry: state=%0d motor=%b, required 4/0", state, motor_on);
        end
        food_empty = 0;
        fault_clr = 1;
        step();
        fault_clr = 0;
        manual_req = 0;
        tests++;
        if (state !== 3'd0 || feed_count !== 2'd0) begin
            fails++;
            $display("FAIL fault_entry_clear: state=%0d cnt=%0d, required 0/0", state, feed_count);
        end
    endtask

    task automatic test_boundaries();
        int tk, cy;
        bit motor_seen;
        enable = 1; interval = 2; portion = 0; manual_req = 0; period = 4;
        do_reset();
        motor_seen = 0; cy = 0;
        while (state !== 3'd3 && cy < 60) begin
            step();
            if (motor_on) motor_seen = 1;
            cy++;
        end
        tests++;
        if (cy >= 60 || motor_seen || state !== 3'd3 || remaining !== 17'(CD) || feed_count !== 2'd0) begin
            fails++;
            $display("FAIL zero_portion: state=%0d rem=%0d motor_seen=%b cnt=%0d, required 3/%0d/0/0",
                     state, remaining, motor_seen, feed_count, CD);
        end
        interval = 0;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        tests++;
        if (state !== 3'd0 || timer_en !== 1'b0) begin
            fails++;
            $display("FAIL zero_interval: state=%0d ten=%b, required 0/0", state, timer_en);
        end
        interval = 2; portion = 1;
        do_reset();
        step();
        cy = 0;
        while (!(state == 3'd1 && remaining == 17'd1 && phase == period - 1) && cy < 60) begin
            step();
            cy++;
        end
        manual_req = 1;
        step();
        tests++;
        if (cy >= 60 || state !== 3'd2 || remaining !== 17'd1) begin
            fails++;
            $display("FAIL coincident_entry: state=%0d rem=%0d, required 2/1", state, remaining);
        end
        dwell(3'd2, 60, tk, cy);
        dwell(3'd3, 60, tk, cy);
        tests++;
        if (cy >= 60 || state !== 3'd1 || remaining !== 17'd2 || feed_count !== 2'd1) begin
            fails++;
            $display("FAIL coincident_single: state=%0d rem=%0d cnt=%0d, required 1/2/1",
                     state, remaining, feed_count);
        end
        manual_req = 0;
    endtask

    task automatic test_enable_drop();
        int tk, cy;
        enable = 1; interval = 5; portion = 2; manual_req = 0; period = 4;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        enable = 0;
        step();
        tests++;
        if (state !== 3'd0 || remaining !== '0 || timer_en !== 1'b0) begin
            fails++;
            $display("FAIL enable_drop_wait: state=%0d rem=%0d ten=%b, required 0/0/0",
                     state, remaining, timer_en);
        end
        enable = 1;
        step();
        tests++;
        if (state !== 3'd1 || remaining !== 17'd5) begin
            fails++;
            $display("FAIL enable_reload: state=%0d rem=%0d, required 1/5", state, remaining);
        end
        dwell(3'd1, 100, tk, cy);
        enable = 0;
        dwell(3'd2, 100, tk, cy);
        tests++;
        if (cy >= 100 || tk != 2 || state !== 3'd3 || feed_count !== 2'd1) begin
            fails++;
            $display("FAIL enable_drop_dispense: ticks=%0d state=%0d cnt=%0d, required 2/3/1",
                     tk, state, feed_count);
        end
        dwell(3'd3, 100, tk, cy);
        tests++;
        if (cy >= 100 || state !== 3'd0 || remaining !== '0) begin
            fails++;
            $display("FAIL enable_drop_idle: state=%0d rem=%0d, required 0/0", state, remaining);
        end
    endtask

    task automatic test_saturation();
        int feeds, cy;
        logic [2:0] prev;
        enable = 1; interval = 1; portion = 1; manual_req = 0; period = 2;
        do_reset();
        feeds = 0; cy = 0;
        while (feeds < 5 && cy < 500) begin
            prev = state;
            step();
            if (prev == 3'd2 && state == 3'd3) feeds++;
            cy++;
        end
        tests++;
        if (feeds != 5 || feed_count !== 2'd3) begin
            fails++;
            $display("FAIL saturation: feeds=%0d cnt=%0d, required 5/3", feeds, feed_count);
        end
        cy = 0;
        while (state !== 3'd2 && cy < 100) begin
            step();
            cy++;
        end
        reset = 1;
        step();
        reset = 0;
        tests++;
        if (cy >= 100 || state !== 3'd0 || motor_on !== 1'b0 || fault !== 1'b0 ||
            timer_en !== 1'b0 || remaining !== '0 || feed_count !== '0) begin
            fails++;
            $display("FAIL reset_mid_dispense: state=%0d motor=%b ten=%b rem=%0d cnt=%0d, required 0",
                     state, motor_on, timer_en, remaining, feed_count);
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_st;
        rand_tick = 1;
        enable = 1; interval = 2; portion = 1; manual_req = 0; food_empty = 0; fault_clr = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            enable     = ($urandom_range(0, 19) != 0);
            interval   = IW'($urandom_range(0, 4));
            portion    = PW'($urandom_range(0, 3));
            fault_clr  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) manual_req = ~manual_req;
            if (food_empty) food_empty = ($urandom_range(0, 4) != 0);
            else            food_empty = ($urandom_range(0, 59) == 0);
            step();
            exp_st = 3'(m_st);
            tests++;
            if (state !== exp_st || remaining !== IW'(m_rem) || feed_count !== CW'(m_cnt) ||
                motor_on !== (m_st == 2) || fault !== (m_st == 4) ||
                timer_en !== (m_st >= 1 && m_st <= 3)) begin
                fails++;
                $display("FAIL random[%0d]: state=%0d rem=%0d cnt=%0d motor=%b fault=%b ten=%b, required state=%0d rem=%0d cnt=%0d",
                         i, state, remaining, feed_count, motor_on, fault, timer_en,
                         m_st, m_rem, m_cnt);
            end
        end
        reset = 0;
        rand_tick = 0;
    endtask

    initial begin
        test_reset();
        test_auto_cycle();
        test_manual();
        test_fault();
        test_boundaries();
        test_enable_drop();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation still running at 2 ms, required completion");
        $fatal(1);
    end

endmodule
